// File: rtl/mmio_tx_port.sv
// mmio_tx_port: memory-mapped transmit FIFO with DATA/STATUS/CTRL/COUNT registers and a ready/valid output stream.
module mmio_tx_port #(
  parameter logic [7:0] BASE = 8'hF0,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Mem_OUT,
  input  logic [7:0] Mem_ADDR,
  input  logic       write,
  output logic [7:0] Mem_IN,
  output logic       sel,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic ovf, enable, irq_en;
  logic empty, full, pop, push, drop, wr_data, wr_stat, wr_ctrl;
  logic [1:0] off;
  logic [7:0] head, rdata;
  always_comb begin
    off = Mem_ADDR[1:0];
    sel = Mem_ADDR[7:2] == BASE[7:2];
    empty = count == '0;
    full = count == CW'(DEPTH);
    head = empty ? 8'h00 : mem[rd_ptr];
    out_valid = enable & ~empty;
    out_data = head;
    pop = out_valid & out_ready;
    wr_data = sel & write & (off == 2'd0);
    wr_stat = sel & write & (off == 2'd1);
    wr_ctrl = sel & write & (off == 2'd2);
    // a full FIFO still takes a push when the head leaves on the same edge
    push = wr_data & (~full | pop);
    drop = wr_data & full & ~pop;
    rdata = off == 2'd0 ? head :
            off == 2'd1 ? {4'b0, enable, ovf, full, empty} :
            off == 2'd2 ? {6'b0, irq_en, enable} : 8'(count);
    Mem_IN = sel ? rdata : 8'h00;
    irq = irq_en & (empty | ovf);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      enable <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      count <= count + CW'(push) - CW'(pop);
      ovf <= drop ? 1'b1 : (wr_stat & Mem_OUT[2]) ? 1'b0 : ovf;
      enable <= wr_ctrl ? Mem_OUT[0] : enable;
      irq_en <= wr_ctrl ? Mem_OUT[1] : irq_en;
    end
  always_ff @(posedge clk)
    if (push && !reset) mem[wr_ptr] <= Mem_OUT;
endmodule

// File: tb/tb_mmio_tx_port.sv
// tb_mmio_tx_port: register-level vector table plus scoreboarded stream checks for mmio_tx_port.
module tb_mmio_tx_port;
  localparam logic [7:0] B0 = 8'hF0, B1 = 8'hF1, B2 = 8'hF2, B3 = 8'hF3;
  logic clk = 1'b0, reset = 1'b1, write = 1'b0, out_ready = 1'b0;
  logic [7:0] Mem_OUT = 8'h00, Mem_ADDR = 8'h00;
  logic [7:0] Mem_IN, out_data;
  logic sel, out_valid, irq;
  int n_vec = 0, n_err = 0;
  logic [7:0] sb [$];
  typedef struct {
    logic we;
    logic [7:0] wa, wd;
    logic push;
    logic [7:0] ra, exp;
  } vec_t;
  vec_t tbl [20];
  mmio_tx_port #(.BASE(8'hF0), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .Mem_OUT(Mem_OUT), .Mem_ADDR(Mem_ADDR), .write(write),
    .Mem_IN(Mem_IN), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    Mem_ADDR = a;
    Mem_OUT = d;
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    Mem_ADDR = a;
    #1;
    check(name, Mem_IN, exp);
  endtask
  // pops happen at the next rising edge; sample the stream on the falling edge before it
  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stream: unexpected byte %h with empty scoreboard", out_data);
      end else check("stream", out_data, sb.pop_front());
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{1'b0, B0, 8'h00, 1'b0, B1, 8'h01};
    tbl[1]  = '{1'b0, B0, 8'h00, 1'b0, B3, 8'h00};
    tbl[2]  = '{1'b0, B0, 8'h00, 1'b0, B2, 8'h00};
    tbl[3]  = '{1'b1, B0, 8'hA1, 1'b1, B3, 8'h01};
    tbl[4]  = '{1'b1, B0, 8'hA2, 1'b1, B0, 8'hA1};
    tbl[5]  = '{1'b1, B0, 8'hA3, 1'b1, B3, 8'h03};
    tbl[6]  = '{1'b1, B0, 8'hA4, 1'b1, B1, 8'h02};
    tbl[7]  = '{1'b1, B0, 8'hA5, 1'b0, B1, 8'h06};
    tbl[8]  = '{1'b0, B0, 8'h00, 1'b0, B3, 8'h04};
    tbl[9]  = '{1'b0, B0, 8'h00, 1'b0, B0, 8'hA1};
    tbl[10] = '{1'b1, B1, 8'h00, 1'b0, B1, 8'h06};
    tbl[11] = '{1'b1, B3, 8'hFF, 1'b0, B3, 8'h04};
    tbl[12] = '{1'b1, 8'hE0, 8'h99, 1'b0, B3, 8'h04};
    tbl[13] = '{1'b0, B0, 8'h00, 1'b0, 8'h01, 8'h00};
    tbl[14] = '{1'b1, 8'hF5, 8'h04, 1'b0, B1, 8'h06};
    tbl[15] = '{1'b1, B1, 8'h04, 1'b0, B1, 8'h02};
    tbl[16] = '{1'b1, B2, 8'hFC, 1'b0, B2, 8'h00};
    tbl[17] = '{1'b1, B2, 8'h02, 1'b0, B2, 8'h02};
    tbl[18] = '{1'b1, B2, 8'h00, 1'b0, B1, 8'h02};
    tbl[19] = '{1'b0, B0, 8'h00, 1'b0, B0, 8'hA1};
    tick();
    tick();
    check("reset out_valid", {7'b0, out_valid}, 8'h00);
    check("reset irq", {7'b0, irq}, 8'h00);
    check("reset out_data", out_data, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      Mem_ADDR = tbl[i].wa;
      Mem_OUT = tbl[i].wd;
      write = tbl[i].we;
      if (tbl[i].push) sb.push_back(tbl[i].wd);
      tick();
      write = 1'b0;
      rd(tbl[i].ra, tbl[i].exp, $sformatf("vec%0d", i));
      check($sformatf("vec%0d out_valid", i), {7'b0, out_valid}, 8'h00);
    end
    Mem_ADDR = 8'h01;
    #1 check("sel outside", {7'b0, sel}, 8'h00);
    Mem_ADDR = B3;
    #1 check("sel inside", {7'b0, sel}, 8'h01);
    wr(B2, 8'h01);
    check("enabled valid", {7'b0, out_valid}, 8'h01);
    check("enabled head", out_data, 8'hA1);
    out_ready = 1'b1;
    sb.push_back(8'h55);
    wr(B0, 8'h55);
    out_ready = 1'b0;
    rd(B3, 8'h04, "push+pop count");
    rd(B1, 8'h0A, "push+pop status");
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check("drained valid", {7'b0, out_valid}, 8'h00);
    rd(B3, 8'h00, "drained count");
    check("drained sb", 8'(sb.size()), 8'h00);
    for (int i = 0; i < 6; i++) begin
      out_ready = i[0];
      sb.push_back(8'(8'h30 + i));
      wr(B0, 8'(8'h30 + i));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10 && out_valid; k++) tick();
    out_ready = 1'b0;
    check("wrap valid", {7'b0, out_valid}, 8'h00);
    check("wrap sb", 8'(sb.size()), 8'h00);
    rd(B3, 8'h00, "wrap count");
    wr(B2, 8'h02);
    check("irq empty", {7'b0, irq}, 8'h01);
    wr(B2, 8'h01);
    check("irq off", {7'b0, irq}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'(8'h61 + i));
      wr(B0, 8'(8'h61 + i));
    end
    rd(B3, 8'h03, "pre-reset count");
    check("pre-reset valid", {7'b0, out_valid}, 8'h01);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    check("async valid", {7'b0, out_valid}, 8'h00);
    check("async irq", {7'b0, irq}, 8'h00);
    check("async out_data", out_data, 8'h00);
    check("async count", Mem_IN, 8'h00);
    tick();
    reset = 1'b0;
    wr(B2, 8'h01);
    sb.push_back(8'h77);
    wr(B0, 8'h77);
    check("post-reset head", out_data, 8'h77);
    rd(B3, 8'h01, "post-reset count");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post-reset sb", 8'(sb.size()), 8'h00);
    check("post-reset empty", {7'b0, out_valid}, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_tx_port.md
MMIO_TX_PORT -- requirements
Module: mmio_tx_port

Interface
REQ-001 SHALL have parameter BASE, default 8'hF0, base address of a 4-byte register window (BASE[1:0] = 0).
REQ-002 SHALL have parameter DEPTH, default 4, FIFO depth (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Mem_OUT  input  8  write data driven by the processor.
REQ-006 SHALL have port Mem_ADDR  input  8  processor address.
REQ-007 SHALL have port write  input  1  processor write strobe, sampled at rising clk.
REQ-008 SHALL have port Mem_IN  output  8  read data returned to the processor.
REQ-009 SHALL have port sel  output  1  high when Mem_ADDR[7:2] == BASE[7:2].
REQ-010 SHALL have port out_data  output  8  FIFO head byte toward the consumer.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-013 SHALL have port irq  output  1  interrupt request, level.

Function
REQ-014 SHALL act as a bus responder on the processor memory interface; register map, offset = Mem_ADDR[1:0]: 0 DATA, 1 STATUS, 2 CTRL, 3 COUNT.
REQ-015 Reads SHALL be combinational and side-effect free: Mem_IN = selected register when sel=1, else 8'h00.
REQ-016 DATA read SHALL return the FIFO head (8'h00 when empty); DATA write (sel & write & offset 0) SHALL push Mem_OUT at the clock edge.
REQ-017 STATUS read SHALL be {4'b0, enable, ovf, full, empty}; STATUS write with Mem_OUT[2]=1 SHALL clear ovf (W1C), other bits ignored.
REQ-018 CTRL SHALL be read/write: bit0 enable, bit1 irq_en; bits 7:2 read 0.
REQ-019 COUNT read SHALL return occupancy 0..DEPTH, zero-extended to 8 bits.
REQ-020 FIFO SHALL be a circular buffer with rd/wr pointers wrapping modulo DEPTH and a count register; full = (count == DEPTH), empty = (count == 0).
REQ-021 out_valid SHALL equal enable & !empty; out_data SHALL equal the head entry (8'h00 when empty).
REQ-022 Pop SHALL occur at the edge where out_valid & out_ready = 1; rd pointer +1, count -1.
REQ-023 Push SHALL be accepted when !full, or when full and a pop occurs in the same cycle; push+pop same cycle SHALL leave count unchanged.
REQ-024 Push while full without a same-cycle pop SHALL be dropped, FIFO contents unchanged, ovf set to 1.
REQ-025 ovf set and W1C clear in the same cycle SHALL leave ovf = 1 (set wins).
REQ-026 Writes to COUNT and writes with sel=0 SHALL have no effect; enable=0 SHALL hold FIFO contents and force out_valid=0.
REQ-027 irq SHALL equal irq_en & (empty | ovf), derived combinationally from registered state.
REQ-028 out_valid SHALL not depend combinationally on out_ready.

Reset
REQ-029 On reset assertion, asynchronously: pointers=0, count=0, ovf=0, enable=0, irq_en=0; hence out_valid=0, irq=0, out_data=8'h00.
REQ-030 Reset mid-transfer SHALL discard all FIFO contents; no pop or push is recorded on the edge where reset is high.
REQ-031 FIFO storage array SHALL need no reset; its contents are unobservable while empty.

Verification
REQ-032 Reset, then read BASE+1 and BASE+3 -> Mem_IN = 8'h01 and 8'h00; out_valid=0, irq=0.
REQ-033 enable=0; write 8'hA1,A2,A3,A4 to BASE+0; fifth write 8'hA5 -> COUNT=4, STATUS=8'h06 (full, ovf); head 8'hA1; write 8'h04 to BASE+1 -> STATUS=8'h02.
REQ-034 From full FIFO, CTRL=8'h01, out_ready=1 for 4 cycles -> out_data A1,A2,A3,A4 on consecutive edges; then out_valid=0, COUNT=0.
REQ-035 Full FIFO, enable=1, out_ready=1, simultaneous DATA write 8'h55 -> accepted, COUNT stays 4, ovf stays 0, 8'h55 emerges after A2..A4.
REQ-036 Push 6 and pop 6 bytes interleaved with DEPTH=4 (pointer wrap) -> output order equals input order, no loss; CTRL=8'h02 with empty -> irq=1.
REQ-037 Assert reset with COUNT=3 and out_valid=1 -> out_valid, irq and COUNT go 0 without waiting for clk; after release, first push of 8'h77 appears as head.
